// File: rtl/step_debug_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// step_debug_pkg
// Shared definitions for the step/run debug controller:
//   - mode encodings presented on the 2-bit mode input
//   - FSM state enumeration
//   - width of the optional step counter (present when STEP_CNT_EN is defined)
// -----------------------------------------------------------------------------
package step_debug_pkg;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_BURST  = 2'b01;
  localparam logic [1:0] MODE_RUN    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_STEP  = 2'b01,
    ST_BURST = 2'b10,
    ST_RUN   = 2'b11
  } state_e;

  localparam int STEP_CNT_W = 16;

endpackage

// File: rtl/step_debug_ctrl_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Push-button conditioner: 2-flop synchroniser, stable-level filter and
// rising-edge detector.
//   clk, rst  : system clock, synchronous active-high reset
//   btn       : raw asynchronous button level
//   press     : one-cycle pulse when the accepted level rises
// The accepted level changes only after DB_CYCLES consecutive synchronised
// samples disagree with it. A level rising at cycle 0 yields press at
// cycle DB_CYCLES+2.
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          level_dly_q, level_dly_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state: synchroniser shift, stable counter and accepted level.
  always_comb begin
    sync1_d     = btn;
    sync2_d     = sync1_q;
    level_dly_d = level_q;
    level_d     = level_q;
    cnt_d       = cnt_q;
    if (sync2_q != level_q) begin
      // cnt_q counts the disagreeing samples already seen; this one is the last.
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        level_d = level_q;
        cnt_d   = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      cnt_q       <= cnt_d;
    end
  end

  assign press = level_q & ~level_dly_q;

endmodule

// File: rtl/step_debug_ctrl.sv
// -----------------------------------------------------------------------------
// step_debug_ctrl
// Push-button step/run controller and LED probe display for the teaching CPU.
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   btn          : raw push button (asynchronous)
//   mode         : 00 single, 01 burst, 10 run, 11 single
//   SW           : probe channel select
//   page         : LED_W-wide slice select within the selected probe word
//   probe_data   : NCH flattened probe words, channel k at [k*DATA_W +: DATA_W]
//   cpu_halted   : CPU has halted (aborts burst/run, blocks run entry)
//   step_en      : CPU clock enable, one cycle per step
//   busy         : controller is not idle
//   LED          : registered slice of the selected probe word
//   step_cnt     : (only with STEP_CNT_EN defined) wrapping count of step_en
// Optional feature macro: STEP_CNT_EN.
// -----------------------------------------------------------------------------
module step_debug_ctrl
  import step_debug_pkg::*;
#(
  parameter  int DATA_W    = 32,
  parameter  int NCH       = 8,
  parameter  int LED_W     = 8,
  parameter  int DB_CYCLES = 4,
  parameter  int BURST     = 4,
  localparam int SW_W      = $clog2(NCH),
  localparam int PAGES     = DATA_W / LED_W,
  localparam int PG_W      = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn,
  input  logic [1:0]            mode,
  input  logic [SW_W-1:0]       SW,
  input  logic [PG_W-1:0]       page,
  input  logic [NCH*DATA_W-1:0] probe_data,
  input  logic                  cpu_halted,
  output logic                  step_en,
  output logic                  busy,
  output logic [LED_W-1:0]      LED
`ifdef STEP_CNT_EN
  ,
  output logic [STEP_CNT_W-1:0] step_cnt
`endif
);

  localparam logic [7:0] BURST_LOAD = 8'(BURST);

  logic       press_s;
  logic       step_en_s;
  state_e     state_q, state_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic       busy_q, busy_d;
  logic [LED_W-1:0] led_q, led_d;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_btn_debounce (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .press(press_s)
  );

  // FSM next state, burst counter and step pulse. step_en is decided in the
  // same cycle as the exit condition so that an abort never issues a pulse.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    step_en_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press_s) begin
          case (mode)
            MODE_BURST: begin
              state_d     = ST_BURST;
              burst_cnt_d = BURST_LOAD;
            end
            MODE_RUN: begin
              // A halted core may still be single-stepped, but never run.
              if (!cpu_halted) begin
                state_d = ST_RUN;
              end else begin
                state_d = ST_IDLE;
              end
            end
            default: state_d = ST_STEP;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        step_en_s = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_BURST: begin
        if (cpu_halted) begin
          state_d     = ST_IDLE;
          burst_cnt_d = 8'd0;
        end else begin
          step_en_s = 1'b1;
          if (burst_cnt_q == 8'd1) begin
            state_d     = ST_IDLE;
            burst_cnt_d = 8'd0;
          end else begin
            state_d     = ST_BURST;
            burst_cnt_d = burst_cnt_q - 8'd1;
          end
        end
      end
      ST_RUN: begin
        if (press_s || cpu_halted) begin
          state_d = ST_IDLE;
        end else begin
          step_en_s = 1'b1;
          state_d   = ST_RUN;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        burst_cnt_d = 8'd0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Probe display mux: channel words, then LED-wide pages of the chosen word.
  logic [DATA_W-1:0] ch_words [NCH];
  logic [LED_W-1:0]  page_words [2**PG_W];
  logic [DATA_W-1:0] ch_sel_s;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign ch_words[g] = probe_data[g*DATA_W +: DATA_W];
  end

  assign ch_sel_s = ch_words[SW];

  for (genvar p = 0; p < 2**PG_W; p++) begin : g_pg
    if (p < PAGES) begin : g_real
      assign page_words[p] = ch_sel_s[p*LED_W +: LED_W];
    end else begin : g_pad
      assign page_words[p] = '0;
    end
  end

  // LED slice selection for the next register update.
  always_comb begin
    led_d = page_words[page];
  end

  // Controller and display registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      burst_cnt_q <= 8'd0;
      busy_q      <= 1'b0;
      led_q       <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      busy_q      <= busy_d;
      led_q       <= led_d;
    end
  end

  assign step_en = step_en_s;
  assign busy    = busy_q;
  assign LED     = led_q;

`ifdef STEP_CNT_EN
  logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;

  // Wrapping count of issued step pulses.
  always_comb begin
    if (step_en_s) begin
      step_cnt_d = step_cnt_q + STEP_CNT_W'(1);
    end else begin
      step_cnt_d = step_cnt_q;
    end
  end

  // Step counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt_q <= '0;
    end else begin
      step_cnt_q <= step_cnt_d;
    end
  end

  assign step_cnt = step_cnt_q;
`else
  // Step counter not built in this configuration.
`endif

endmodule

// File: tb/tb_step_debug_ctrl.sv
// -----------------------------------------------------------------------------
// tb_step_debug_ctrl
// Scoreboard bench for step_debug_ctrl (DATA_W=32, NCH=8, LED_W=8,
// DB_CYCLES=4, BURST=4). Stimulus pushes expected step pulse cycles and
// per-cycle signal checks into queues; a monitor on the falling edge pops and
// compares. Optional STEP_CNT_EN section exercises the counter wrap.
// -----------------------------------------------------------------------------
module tb_step_debug_ctrl;

  localparam int DATA_W = 32;
  localparam int NCH    = 8;
  localparam int LED_W  = 8;

  localparam int K_STEP = 0;
  localparam int K_BUSY = 1;
  localparam int K_LED  = 2;
  localparam int K_CNT  = 3;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
  } chk_t;

  logic                  clk;
  logic                  rst;
  logic                  btn;
  logic [1:0]            mode;
  logic [2:0]            SW;
  logic [1:0]            page;
  logic [NCH*DATA_W-1:0] probe_data;
  logic                  cpu_halted;
  logic                  step_en;
  logic                  busy;
  logic [LED_W-1:0]      LED;
`ifdef STEP_CNT_EN
  logic [15:0]           step_cnt;
`endif

  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_fail = 0;
  int   pq[$];
  chk_t cq[$];
  int   exp_c;
  logic [31:0] act;

  step_debug_ctrl #(
    .DATA_W(DATA_W), .NCH(NCH), .LED_W(LED_W), .DB_CYCLES(4), .BURST(4)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .mode(mode), .SW(SW), .page(page),
    .probe_data(probe_data), .cpu_halted(cpu_halted),
    .step_en(step_en), .busy(busy), .LED(LED)
`ifdef STEP_CNT_EN
    , .step_cnt(step_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: step pulses against the pulse queue, then any per-cycle checks.
  always @(negedge clk) begin
    if (step_en === 1'b1) begin
      n_vec++;
      if (pq.size() == 0) begin
        n_fail++;
        $display("FAIL step_pulse: cycle %0d got unexpected pulse, required none", cyc);
      end else begin
        exp_c = pq.pop_front();
        if (exp_c != cyc) begin
          n_fail++;
          $display("FAIL step_pulse: pulse at cycle %0d, required at cycle %0d", cyc, exp_c);
        end
      end
    end else if (pq.size() != 0 && pq[0] <= cyc) begin
      exp_c = pq.pop_front();
      n_vec++;
      n_fail++;
      $display("FAIL step_pulse: no pulse (step_en=%b), required at cycle %0d", step_en, exp_c);
    end
    for (int i = cq.size() - 1; i >= 0; i--) begin
      if (cq[i].cyc == cyc) begin
        case (cq[i].kind)
          K_STEP:  act = {31'd0, step_en};
          K_BUSY:  act = {31'd0, busy};
          K_LED:   act = {24'd0, LED};
`ifdef STEP_CNT_EN
          K_CNT:   act = {16'd0, step_cnt};
`endif
          default: act = 32'hxxxx_xxxx;
        endcase
        n_vec++;
        if (act !== cq[i].val) begin
          n_fail++;
          $display("FAIL chk_kind%0d: cycle %0d got 0x%0h, required 0x%0h",
                   cq[i].kind, cyc, act, cq[i].val);
        end
        cq.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input int c, input int kind, input logic [31:0] v);
    chk_t e;
    e.cyc  = c;
    e.kind = kind;
    e.val  = v;
    cq.push_back(e);
  endtask

  task automatic press_btn(input int hold, input int gap);
    btn = 1'b1;
    tick(hold);
    btn = 1'b0;
    tick(gap);
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c0;
    int c1;
    rst        = 1'b1;
    btn        = 1'b0;
    mode       = 2'b00;
    SW         = 3'd0;
    page       = 2'd0;
    cpu_halted = 1'b0;
    for (int k = 0; k < NCH; k++) probe_data[k*DATA_W +: DATA_W] = 32'h1111_1111 * k;
    probe_data[0 +: DATA_W] = 32'h1234_5678;

    // Reset: outputs cleared while rst held for two cycles.
    chk(1, K_BUSY, 32'd0); chk(1, K_LED, 32'd0); chk(1, K_STEP, 32'd0);
    chk(2, K_BUSY, 32'd0); chk(2, K_LED, 32'd0);
    chk(3, K_LED, 32'h78);
    tick(2);
    rst = 1'b0;
    tick(4);

    // Single step: one pulse DB_CYCLES+3 cycles after the button rises.
    c0 = cyc;
    pq.push_back(c0 + 7);
    chk(c0 + 7, K_BUSY, 32'd1); chk(c0 + 8, K_BUSY, 32'd0); chk(c0 + 8, K_STEP, 32'd0);
    press_btn(10, 14);

    // Two-cycle glitch: filtered out.
    c0 = cyc;
    chk(c0 + 7, K_STEP, 32'd0); chk(c0 + 8, K_BUSY, 32'd0);
    press_btn(2, 14);

    // Mode 11 behaves as single.
    mode = 2'b11;
    c0 = cyc;
    pq.push_back(c0 + 7);
    chk(c0 + 8, K_BUSY, 32'd0);
    press_btn(6, 14);

    // Burst of four consecutive pulses.
    mode = 2'b01;
    c0 = cyc;
    for (int i = 0; i < 4; i++) pq.push_back(c0 + 7 + i);
    chk(c0 + 7, K_BUSY, 32'd1); chk(c0 + 10, K_BUSY, 32'd1); chk(c0 + 11, K_BUSY, 32'd0);
    press_btn(6, 14);

    // Burst aborted by halt at the second pulse: one pulse only.
    c0 = cyc;
    pq.push_back(c0 + 7);
    chk(c0 + 8, K_STEP, 32'd0); chk(c0 + 9, K_BUSY, 32'd0);
    btn = 1'b1; tick(6); btn = 1'b0; tick(2);
    cpu_halted = 1'b1; tick(1);
    cpu_halted = 1'b0; tick(11);

    // Run, stopped by a second press (no pulse in the exit cycle).
    mode = 2'b10;
    c0 = cyc;
    for (int i = 7; i <= 19; i++) pq.push_back(c0 + i);
    chk(c0 + 20, K_STEP, 32'd0); chk(c0 + 20, K_BUSY, 32'd1); chk(c0 + 21, K_BUSY, 32'd0);
    press_btn(6, 8);
    press_btn(6, 14);

    // Run, stopped by halt; then a run press while halted stays idle.
    c0 = cyc;
    for (int i = 7; i <= 9; i++) pq.push_back(c0 + i);
    chk(c0 + 10, K_STEP, 32'd0); chk(c0 + 11, K_BUSY, 32'd0);
    btn = 1'b1; tick(6); btn = 1'b0; tick(4);
    cpu_halted = 1'b1; tick(10);
    c1 = cyc;
    chk(c1 + 7, K_STEP, 32'd0); chk(c1 + 7, K_BUSY, 32'd0); chk(c1 + 8, K_BUSY, 32'd0);
    press_btn(6, 14);

    // Single step still works on a halted core.
    mode = 2'b00;
    c0 = cyc;
    pq.push_back(c0 + 7);
    chk(c0 + 8, K_BUSY, 32'd0);
    press_btn(6, 14);
    cpu_halted = 1'b0;

    // Display: channel 5 pages, one-cycle latency.
    probe_data[5*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    SW = 3'd5; page = 2'd0; c0 = cyc;
    chk(c0 + 1, K_LED, 32'hEF);
    tick(2);
    page = 2'd1; c0 = cyc;
    chk(c0, K_LED, 32'hEF); chk(c0 + 1, K_LED, 32'hBE);
    tick(2);
    page = 2'd2; c0 = cyc;
    chk(c0 + 1, K_LED, 32'hAD);
    tick(2);
    page = 2'd3; c0 = cyc;
    chk(c0 + 1, K_LED, 32'hDE);
    tick(2);
    SW = 3'd0; c0 = cyc;
    chk(c0, K_LED, 32'hDE); chk(c0 + 1, K_LED, 32'h12);
    tick(2);
    probe_data[0 +: DATA_W] = 32'hA500_0000; c0 = cyc;
    chk(c0, K_LED, 32'h12); chk(c0 + 1, K_LED, 32'hA5);
    tick(2);

    // Reset mid-run: step_en low and idle the next cycle.
    mode = 2'b10;
    c0 = cyc;
    for (int i = 7; i <= 9; i++) pq.push_back(c0 + i);
    chk(c0 + 10, K_STEP, 32'd0); chk(c0 + 10, K_BUSY, 32'd0); chk(c0 + 11, K_BUSY, 32'd0);
`ifdef STEP_CNT_EN
    chk(c0 + 10, K_CNT, 32'd0);
`endif
    btn = 1'b1; tick(6); btn = 1'b0; tick(3);
    rst = 1'b1; tick(1);
    rst = 1'b0; tick(12);

`ifdef STEP_CNT_EN
    // Counter wrap: 65536 pulses bring step_cnt back to zero.
    c0 = cyc;
    chk(c0 + 7, K_CNT, 32'd0);
    chk(c0 + 8, K_CNT, 32'd1);
    for (int i = 0; i < 65536; i++) pq.push_back(c0 + 7 + i);
    chk(c0 + 7 + 65535, K_CNT, 32'h0000_FFFF);
    chk(c0 + 7 + 65536, K_CNT, 32'd0);
    chk(c0 + 7 + 65536, K_STEP, 32'd0);
    btn = 1'b1; tick(6); btn = 1'b0; tick(65537);
    cpu_halted = 1'b1; tick(3);
    cpu_halted = 1'b0; tick(4);
`endif

    tick(5);
    n_vec++;
    if (pq.size() != 0) begin
      n_fail++;
      $display("FAIL pulse_queue_drain: %0d expected pulses never seen, required 0", pq.size());
    end
    n_vec++;
    if (cq.size() != 0) begin
      n_fail++;
      $display("FAIL check_queue_drain: %0d checks never reached, required 0", cq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
